// File: rtl/risc_pkg.sv
// Shared types for the multicycle sequencer: FSM states, opcode map,
// opcode classes and the bundle of datapath control strobes.
package risc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    ERROR
  } state_t;

  localparam logic [4:0] OP_ALU_LAST = 5'h0B;
  localparam logic [4:0] OP_ADDI     = 5'h0C;
  localparam logic [4:0] OP_LOAD     = 5'h0D;
  localparam logic [4:0] OP_STORE    = 5'h0E;
  localparam logic [4:0] OP_BEQ      = 5'h0F;
  localparam logic [4:0] OP_JMP      = 5'h10;
  localparam logic [4:0] OP_NOP      = 5'h11;
  localparam logic [4:0] OP_HALT     = 5'h1F;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_ALUI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_JMP,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic imem_req;
    logic IR_enable;
    logic PC_enable;
    logic reg_enable;
    logic mem_enable;
    logic reg_write;
    logic mem_write;
    logic load;
    logic ALU_src;
    logic branch;
    logic jump;
    logic immediate_signal;
    logic halted;
    logic bus_error;
  } ctrl_t;

endpackage

// File: rtl/risc_op_classify.sv
// Combinational opcode-to-class map shared by the decode branch and the
// execute-phase output decode.
module risc_op_classify
  import risc_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode <= OP_ALU_LAST) begin
      op_class = CLS_ALU;
    end else begin
      case (opcode)
        OP_ADDI:  op_class = CLS_ALUI;
        OP_LOAD:  op_class = CLS_LOAD;
        OP_STORE: op_class = CLS_STORE;
        OP_BEQ:   op_class = CLS_BEQ;
        OP_JMP:   op_class = CLS_JMP;
        OP_NOP:   op_class = CLS_NOP;
        OP_HALT:  op_class = CLS_HALT;
        default:  op_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/risc_mc_sequencer.sv
// Multicycle control FSM with memory ready handshakes, wait-state timeout,
// halt/error states. Optional perf counters: define RISC_SEQ_PERF_EN.
module risc_mc_sequencer
  import risc_pkg::*;
#(
  parameter int TIMEOUT      = 16,
  parameter bit ILLEGAL_HALT = 1'b0,
  parameter int PERF_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [4:0] opcode,
  input  logic compare,
  input  logic imem_ready,
  input  logic dmem_ready,
  output logic imem_req,
  output logic IR_enable,
  output logic PC_enable,
  output logic reg_enable,
  output logic mem_enable,
  output logic reg_write,
  output logic mem_write,
  output logic load,
  output logic ALU_src,
  output logic branch,
  output logic jump,
  output logic immediate_signal,
  output logic halted,
  output logic bus_error,
  output logic illegal_op
`ifdef RISC_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] instr_retired,
  output logic [PERF_W-1:0] stall_cycles
`endif
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t      state_reg, state_next;
  logic [4:0]  op_q;
  logic        illegal_q;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic        wait_last;
  op_class_t   dec_cls, q_cls;
  ctrl_t       ctrl_d, ctrl;

  // The branch decision itself is taken in the datapath PC mux.
  logic unused_compare;
  assign unused_compare = compare;

  risc_op_classify u_dec_cls (.opcode(opcode), .op_class(dec_cls));
  risc_op_classify u_q_cls   (.opcode(op_q),   .op_class(q_cls));

  assign wait_last = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= FETCH;
      op_q         <= '0;
      illegal_q    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_q    <= (state_reg == DECODE) && (dec_cls == CLS_ILLEGAL);
      if (state_reg == DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl_d     = '0;
    case (state_reg)
      FETCH: begin
        ctrl_d.imem_req  = 1'b1;
        ctrl_d.IR_enable = 1'b1;
        if (imem_ready)     state_next = DECODE;
        else if (wait_last) state_next = ERROR;
      end
      DECODE: begin
        case (dec_cls)
          CLS_HALT:    state_next = HALT;
          CLS_ILLEGAL: state_next = ILLEGAL_HALT ? HALT : EXEC;
          default:     state_next = EXEC;
        endcase
      end
      EXEC: begin
        ctrl_d.ALU_src          = (q_cls == CLS_ALUI) || (q_cls == CLS_LOAD) || (q_cls == CLS_STORE);
        ctrl_d.immediate_signal = ctrl_d.ALU_src;
        case (q_cls)
          CLS_ALU, CLS_ALUI:   state_next = WB;
          CLS_LOAD, CLS_STORE: state_next = MEM;
          CLS_BEQ: begin
            ctrl_d.branch    = 1'b1;
            ctrl_d.PC_enable = 1'b1;
            state_next       = FETCH;
          end
          CLS_JMP: begin
            ctrl_d.jump      = 1'b1;
            ctrl_d.PC_enable = 1'b1;
            state_next       = FETCH;
          end
          default: begin
            ctrl_d.PC_enable = 1'b1;
            state_next       = FETCH;
          end
        endcase
      end
      MEM: begin
        ctrl_d.mem_enable = 1'b1;
        ctrl_d.load       = (q_cls == CLS_LOAD);
        ctrl_d.mem_write  = (q_cls == CLS_STORE);
        if (dmem_ready) begin
          // A STORE retires in its ready cycle, so only this strobe sees dmem_ready.
          ctrl_d.PC_enable = (q_cls == CLS_STORE);
          state_next       = (q_cls == CLS_LOAD) ? WB : FETCH;
        end else if (wait_last) begin
          state_next = ERROR;
        end
      end
      WB: begin
        ctrl_d.reg_enable = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.PC_enable  = 1'b1;
        ctrl_d.load       = (q_cls == CLS_LOAD);
        state_next        = FETCH;
      end
      HALT:    ctrl_d.halted    = 1'b1;
      ERROR:   ctrl_d.bus_error = 1'b1;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    wait_cnt_next = '0;
    if (((state_reg == FETCH) || (state_reg == MEM)) && (state_next == state_reg))
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Outputs forced low while reset is held so no strobe survives an abort.
  assign ctrl = rst ? ctrl_d : '0;

  assign imem_req         = ctrl.imem_req;
  assign IR_enable        = ctrl.IR_enable;
  assign PC_enable        = ctrl.PC_enable;
  assign reg_enable       = ctrl.reg_enable;
  assign mem_enable       = ctrl.mem_enable;
  assign reg_write        = ctrl.reg_write;
  assign mem_write        = ctrl.mem_write;
  assign load             = ctrl.load;
  assign ALU_src          = ctrl.ALU_src;
  assign branch           = ctrl.branch;
  assign jump             = ctrl.jump;
  assign immediate_signal = ctrl.immediate_signal;
  assign halted           = ctrl.halted;
  assign bus_error        = ctrl.bus_error;
  assign illegal_op       = rst & illegal_q;

`ifdef RISC_SEQ_PERF_EN
  logic [PERF_W-1:0] instr_retired_reg, stall_cycles_reg;
  logic              stall_now;

  assign stall_now = ((state_reg == FETCH) && !imem_ready) ||
                     ((state_reg == MEM) && !dmem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_retired_reg <= '0;
      stall_cycles_reg  <= '0;
    end else begin
      if (ctrl_d.PC_enable && (instr_retired_reg != '1))
        instr_retired_reg <= instr_retired_reg + 1'b1;
      if (stall_now && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign instr_retired = instr_retired_reg;
  assign stall_cycles  = stall_cycles_reg;
`else
  logic [PERF_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_risc_mc_sequencer.sv
// Directed bench for risc_mc_sequencer: per-cycle control-vector checks of
// each instruction class, timeouts, illegal handling and async reset abort.
module tb_risc_mc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] opcode = 5'h00;
  logic compare = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;

  logic imem_req0, IR_enable0, PC_enable0, reg_enable0, mem_enable0, reg_write0, mem_write0;
  logic load0, ALU_src0, branch0, jump0, immediate_signal0, halted0, bus_error0, illegal_op0;
  logic imem_req1, IR_enable1, PC_enable1, reg_enable1, mem_enable1, reg_write1, mem_write1;
  logic load1, ALU_src1, branch1, jump1, immediate_signal1, halted1, bus_error1, illegal_op1;
`ifdef RISC_SEQ_PERF_EN
  logic [15:0] instr_retired0, stall_cycles0, instr_retired1, stall_cycles1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  risc_mc_sequencer #(.TIMEOUT(4), .ILLEGAL_HALT(1'b0), .PERF_W(16)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .compare(compare),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req0), .IR_enable(IR_enable0), .PC_enable(PC_enable0),
    .reg_enable(reg_enable0), .mem_enable(mem_enable0), .reg_write(reg_write0),
    .mem_write(mem_write0), .load(load0), .ALU_src(ALU_src0), .branch(branch0),
    .jump(jump0), .immediate_signal(immediate_signal0), .halted(halted0),
    .bus_error(bus_error0), .illegal_op(illegal_op0)
`ifdef RISC_SEQ_PERF_EN
    , .instr_retired(instr_retired0), .stall_cycles(stall_cycles0)
`endif
  );

  risc_mc_sequencer #(.TIMEOUT(4), .ILLEGAL_HALT(1'b1), .PERF_W(16)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .compare(compare),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req1), .IR_enable(IR_enable1), .PC_enable(PC_enable1),
    .reg_enable(reg_enable1), .mem_enable(mem_enable1), .reg_write(reg_write1),
    .mem_write(mem_write1), .load(load1), .ALU_src(ALU_src1), .branch(branch1),
    .jump(jump1), .immediate_signal(immediate_signal1), .halted(halted1),
    .bus_error(bus_error1), .illegal_op(illegal_op1)
`ifdef RISC_SEQ_PERF_EN
    , .instr_retired(instr_retired1), .stall_cycles(stall_cycles1)
`endif
  );

  // Bit order: imem_req IR PC reg_en mem_en reg_wr mem_wr load ALU_src branch jump imm halted bus_err illegal
  logic [14:0] obs0, obs1;
  assign obs0 = {imem_req0, IR_enable0, PC_enable0, reg_enable0, mem_enable0, reg_write0, mem_write0,
                 load0, ALU_src0, branch0, jump0, immediate_signal0, halted0, bus_error0, illegal_op0};
  assign obs1 = {imem_req1, IR_enable1, PC_enable1, reg_enable1, mem_enable1, reg_write1, mem_write1,
                 load1, ALU_src1, branch1, jump1, immediate_signal1, halted1, bus_error1, illegal_op1};

  localparam logic [14:0] S_F    = 15'h6000;  // imem_req + IR_enable
  localparam logic [14:0] S_D    = 15'h0000;
  localparam logic [14:0] X_ALU  = 15'h0000;
  localparam logic [14:0] X_LS   = 15'h0048;  // ALU_src + immediate_signal
  localparam logic [14:0] X_BEQ  = 15'h1020;  // PC_enable + branch
  localparam logic [14:0] X_JMP  = 15'h1010;  // PC_enable + jump
  localparam logic [14:0] X_NOP  = 15'h1000;
  localparam logic [14:0] X_ILL  = 15'h1001;  // NOP retire + illegal_op
  localparam logic [14:0] M_LD   = 15'h0480;  // mem_enable + load
  localparam logic [14:0] M_ST   = 15'h0500;  // mem_enable + mem_write
  localparam logic [14:0] M_STD  = 15'h1500;  // store ready cycle adds PC_enable
  localparam logic [14:0] W_ALU  = 15'h1A00;  // PC + reg_enable + reg_write
  localparam logic [14:0] W_LD   = 15'h1A80;
  localparam logic [14:0] S_HALT = 15'h0004;
  localparam logic [14:0] H_ILL  = 15'h0005;
  localparam logic [14:0] S_ERR  = 15'h0002;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [14:0] exp);
    check(tag, {17'b0, obs0}, {17'b0, exp});
    tick();
  endtask

  task automatic cyc2(input string tag, input logic [14:0] exp0, input logic [14:0] exp1);
    check(tag, {17'b0, obs0}, {17'b0, exp0});
    check({tag, "_h"}, {17'b0, obs1}, {17'b0, exp1});
    tick();
  endtask

  // Assert reset away from the clock edge, confirm outputs drop, then release.
  task automatic start(input string tag, input logic [4:0] op, input logic ir, input logic dr);
    opcode = op;
    imem_ready = ir;
    dmem_ready = dr;
    rst = 1'b0;
    #1;
    check({tag, "_rst"}, {17'b0, obs0}, 32'd0);
    check({tag, "_rst_h"}, {17'b0, obs1}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ALU reg-reg, zero wait
    start("alu", 5'h03, 1'b1, 1'b0);
    cyc("alu_F", S_F); cyc("alu_D", S_D); cyc("alu_X", X_ALU); cyc("alu_WB", W_ALU);
`ifdef RISC_SEQ_PERF_EN
    check("alu_retired", {16'b0, instr_retired0}, 32'd1);
`endif
    cyc("alu_F2", S_F);
    $display("txn alu op=03 checks=%0d", checks);

    // ALU immediate
    start("addi", 5'h0C, 1'b1, 1'b0);
    cyc("addi_F", S_F); cyc("addi_D", S_D); cyc("addi_X", X_LS); cyc("addi_WB", W_ALU); cyc("addi_F2", S_F);
    $display("txn addi op=0c checks=%0d", checks);

    // LOAD with ready on the 4th MEM cycle (last accepted cycle for TIMEOUT=4)
    start("ld", 5'h0D, 1'b1, 1'b0);
    cyc("ld_F", S_F); cyc("ld_D", S_D); cyc("ld_X", X_LS);
    cyc("ld_M1", M_LD); cyc("ld_M2", M_LD); cyc("ld_M3", M_LD);
    dmem_ready = 1'b1;
    cyc("ld_M4", M_LD);
    dmem_ready = 1'b0;
    cyc("ld_WB", W_LD);
`ifdef RISC_SEQ_PERF_EN
    check("ld_retired", {16'b0, instr_retired0}, 32'd1);
    check("ld_stalls", {16'b0, stall_cycles0}, 32'd3);
`endif
    cyc("ld_F2", S_F);
    $display("txn load op=0d wait=3 checks=%0d", checks);

    // STORE zero wait: PC_enable in the ready MEM cycle
    start("st", 5'h0E, 1'b1, 1'b1);
    cyc("st_F", S_F); cyc("st_D", S_D); cyc("st_X", X_LS); cyc("st_M", M_STD); cyc("st_F2", S_F);
    $display("txn store op=0e checks=%0d", checks);

    // STORE timeout: never ready -> ERROR after 4 MEM cycles
    start("sto", 5'h0E, 1'b1, 1'b0);
    cyc("sto_F", S_F); cyc("sto_D", S_D); cyc("sto_X", X_LS);
    cyc("sto_M1", M_ST); cyc("sto_M2", M_ST); cyc("sto_M3", M_ST); cyc("sto_M4", M_ST);
    cyc("sto_E1", S_ERR);
    dmem_ready = 1'b1;
    cyc("sto_E2", S_ERR);
`ifdef RISC_SEQ_PERF_EN
    check("sto_retired", {16'b0, instr_retired0}, 32'd0);
    check("sto_stalls", {16'b0, stall_cycles0}, 32'd4);
`endif
    $display("txn store-timeout op=0e checks=%0d", checks);

    // Fetch timeout
    start("ft", 5'h03, 1'b0, 1'b0);
    cyc("ft_F1", S_F); cyc("ft_F2", S_F); cyc("ft_F3", S_F); cyc("ft_F4", S_F);
    cyc("ft_E1", S_ERR); cyc("ft_E2", S_ERR);
    $display("txn fetch-timeout checks=%0d", checks);

    // BEQ, JMP, NOP: three cycles each
    compare = 1'b1;
    start("beq", 5'h0F, 1'b1, 1'b0);
    cyc("beq_F", S_F); cyc("beq_D", S_D); cyc("beq_X", X_BEQ); cyc("beq_F2", S_F);
    $display("txn beq op=0f checks=%0d", checks);
    compare = 1'b0;
    start("jmp", 5'h10, 1'b1, 1'b0);
    cyc("jmp_F", S_F); cyc("jmp_D", S_D); cyc("jmp_X", X_JMP); cyc("jmp_F2", S_F);
    $display("txn jmp op=10 checks=%0d", checks);
    start("nop", 5'h11, 1'b1, 1'b0);
    cyc("nop_F", S_F); cyc("nop_D", S_D); cyc("nop_X", X_NOP); cyc("nop_F2", S_F);
    $display("txn nop op=11 checks=%0d", checks);

    // HALT opcode: both variants stop
    start("hlt", 5'h1F, 1'b1, 1'b0);
    cyc2("hlt_F", S_F, S_F); cyc2("hlt_D", S_D, S_D); cyc2("hlt_H1", S_HALT, S_HALT); cyc2("hlt_H2", S_HALT, S_HALT);
    $display("txn halt op=1f checks=%0d", checks);

    // Illegal opcode: dut0 retires it as NOP, dut1 halts
    start("ill", 5'h15, 1'b1, 1'b0);
    cyc2("ill_F", S_F, S_F);
    cyc2("ill_D", S_D, S_D);
    cyc2("ill_X", X_ILL, H_ILL);
    cyc2("ill_F2", S_F, S_HALT);
    cyc2("ill_D2", S_D, S_HALT);
`ifdef RISC_SEQ_PERF_EN
    check("ill_retired", {16'b0, instr_retired0}, 32'd1);
    check("ill_retired_h", {16'b0, instr_retired1}, 32'd0);
`endif
    $display("txn illegal op=15 checks=%0d", checks);

    // Reset in the middle of a LOAD memory wait
    start("rab", 5'h0D, 1'b1, 1'b0);
    cyc("rab_F", S_F); cyc("rab_D", S_D); cyc("rab_X", X_LS); cyc("rab_M1", M_LD); cyc("rab_M2", M_LD);
    check("rab_M3", {17'b0, obs0}, {17'b0, M_LD});
    start("rab2", 5'h03, 1'b1, 1'b0);
    cyc("rab_F2", S_F); cyc("rab_D2", S_D);
    $display("txn reset-abort op=0d checks=%0d", checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
